// File: rtl/alu_cond_writeback.sv
// Condition-check / writeback stage: owns the NZCV flag register and a 4x5 register file, and forwards each accepted op as a registered record.
// Optional macro COND_STATS_EN adds the exec_count / skip_count counters.
module alu_cond_writeback (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [4:0] in_result,
    input  logic [3:0] in_flags,
    input  logic [3:0] in_cond,
    input  logic [1:0] in_flag_we,
    input  logic       in_reg_we,
    input  logic [1:0] in_rd,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] out_result,
    output logic [1:0] out_rd,
    output logic       out_exec,
    output logic       out_we,
    output logic [3:0] flags,
    input  logic [1:0] rd_addr,
    output logic [4:0] rd_data
`ifdef COND_STATS_EN
    ,
    output logic [7:0] exec_count,
    output logic [7:0] skip_count
`endif
);

    typedef enum logic [3:0] {
        COND_EQ = 4'd0,  COND_NE = 4'd1,  COND_CS = 4'd2,  COND_CC = 4'd3,
        COND_MI = 4'd4,  COND_PL = 4'd5,  COND_VS = 4'd6,  COND_VC = 4'd7,
        COND_HI = 4'd8,  COND_LS = 4'd9,  COND_GE = 4'd10, COND_LT = 4'd11,
        COND_GT = 4'd12, COND_LE = 4'd13, COND_AL = 4'd14, COND_NV = 4'd15
    } cond_e;

    logic [3:0] flags_q, flags_d;
    logic [4:0] regs_q [4];
    logic [4:0] regs_d [4];
    logic       out_valid_q, out_valid_d;
    logic [4:0] out_result_q, out_result_d;
    logic [1:0] out_rd_q, out_rd_d;
    logic       out_exec_q, out_exec_d;
    logic       out_we_q, out_we_d;

    logic accept;
    logic exec;

    // Condition is judged against the flags held before this op's own update.
    function automatic logic cond_pass(input logic [3:0] f, input logic [3:0] c);
        logic n, z, cf, v;
        logic pass;
        n  = f[3];
        z  = f[2];
        cf = f[1];
        v  = f[0];
        case (cond_e'(c))
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = cf;
            COND_CC: pass = !cf;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = cf && !z;
            COND_LS: pass = !cf || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            default: pass = 1'b1;
        endcase
        return pass;
    endfunction

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign exec     = cond_pass(flags_q, in_cond);

    always_comb begin
        flags_d = flags_q;
        if (accept && exec) begin
            if (in_flag_we[1]) flags_d[3:2] = in_flags[3:2];
            if (in_flag_we[0]) flags_d[1:0] = in_flags[1:0];
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (accept && exec && in_reg_we) regs_d[in_rd] = in_result;
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_rd_d     = out_rd_q;
        out_exec_d   = out_exec_q;
        out_we_d     = out_we_q;
        if (accept) begin
            out_valid_d  = 1'b1;
            out_result_d = in_result;
            out_rd_d     = in_rd;
            out_exec_d   = exec;
            out_we_d     = exec && in_reg_we;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q      <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_rd_q     <= '0;
            out_exec_q   <= 1'b0;
            out_we_q     <= 1'b0;
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
        end else begin
            flags_q      <= flags_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_rd_q     <= out_rd_d;
            out_exec_q   <= out_exec_d;
            out_we_q     <= out_we_d;
            regs_q       <= regs_d;
        end
    end

    assign flags      = flags_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_rd     = out_rd_q;
    assign out_exec   = out_exec_q;
    assign out_we     = out_we_q;
    assign rd_data    = regs_q[rd_addr];

`ifdef COND_STATS_EN
    logic [7:0] exec_count_q, exec_count_d;
    logic [7:0] skip_count_q, skip_count_d;

    // Both counters wrap naturally at 8 bits.
    always_comb begin
        exec_count_d = exec_count_q;
        skip_count_d = skip_count_q;
        if (accept) begin
            if (exec) exec_count_d = exec_count_q + 8'd1;
            else      skip_count_d = skip_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exec_count_q <= '0;
            skip_count_q <= '0;
        end else begin
            exec_count_q <= exec_count_d;
            skip_count_q <= skip_count_d;
        end
    end

    assign exec_count = exec_count_q;
    assign skip_count = skip_count_q;
`endif

endmodule

// File: tb/tb_alu_cond_writeback.sv
// Self-checking bench for alu_cond_writeback: directed scenarios plus randomized traffic against a behavioural model.
module tb_alu_cond_writeback;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_result;
    logic [3:0] in_flags;
    logic [3:0] in_cond;
    logic [1:0] in_flag_we;
    logic       in_reg_we;
    logic [1:0] in_rd;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_result;
    logic [1:0] out_rd;
    logic       out_exec;
    logic       out_we;
    logic [3:0] flags;
    logic [1:0] rd_addr;
    logic [4:0] rd_data;
`ifdef COND_STATS_EN
    logic [7:0] exec_count;
    logic [7:0] skip_count;
`endif

    int checks   = 0;
    int failures = 0;

    // behavioural model state
    logic [3:0] m_flags;
    logic [4:0] m_regs [4];
    logic       m_ov;
    logic [4:0] m_res;
    logic [1:0] m_rd;
    logic       m_exec;
    logic       m_we;
    logic [7:0] m_ec;
    logic [7:0] m_sc;

    alu_cond_writeback dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_flags(in_flags), .in_cond(in_cond),
        .in_flag_we(in_flag_we), .in_reg_we(in_reg_we), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd),
        .out_exec(out_exec), .out_we(out_we),
        .flags(flags), .rd_addr(rd_addr), .rd_data(rd_data)
`ifdef COND_STATS_EN
        , .exec_count(exec_count), .skip_count(skip_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit cond_ok(input logic [3:0] f, input logic [3:0] c);
        bit n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [4:0] r, input logic [3:0] f,
                         input logic [3:0] c, input logic [1:0] fw, input logic rw,
                         input logic [1:0] rd, input logic ordy);
        in_valid = v; in_result = r; in_flags = f; in_cond = c;
        in_flag_we = fw; in_reg_we = rw; in_rd = rd; out_ready = ordy;
        #1;
    endtask

    // advance one clock edge, stepping the model from the currently driven inputs
    task automatic tick();
        logic [3:0] nf;
        logic [4:0] nr [4];
        logic       nov, nex, nwe, acc, ex;
        logic [4:0] nres;
        logic [1:0] nrd;
        logic [7:0] nec, nsc;
        nf = m_flags; nr = m_regs; nov = m_ov; nres = m_res; nrd = m_rd;
        nex = m_exec; nwe = m_we; nec = m_ec; nsc = m_sc;
        if (reset) begin
            nf = 0; nov = 0; nres = 0; nrd = 0; nex = 0; nwe = 0; nec = 0; nsc = 0;
            for (int i = 0; i < 4; i++) nr[i] = 0;
        end else begin
            acc = in_valid && (!m_ov || out_ready);
            ex  = cond_ok(m_flags, in_cond);
            if (acc) begin
                if (ex && in_flag_we[1]) nf[3:2] = in_flags[3:2];
                if (ex && in_flag_we[0]) nf[1:0] = in_flags[1:0];
                if (ex && in_reg_we) nr[in_rd] = in_result;
                nov = 1; nres = in_result; nrd = in_rd; nex = ex; nwe = ex && in_reg_we;
                if (ex) nec = m_ec + 1; else nsc = m_sc + 1;
            end else if (m_ov && out_ready) begin
                nov = 0;
            end
        end
        @(posedge clk);
        #1;
        m_flags = nf; m_regs = nr; m_ov = nov; m_res = nres; m_rd = nrd;
        m_exec = nex; m_we = nwe; m_ec = nec; m_sc = nsc;
    endtask

    task automatic test_reset();
        reset = 1;
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        tick(); tick();
        reset = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        checks++;
        if ({flags, out_valid, in_ready} !== {4'b0000, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_state flags/ov/ir got=%b_%b_%b exp=0000_0_1", flags, out_valid, in_ready);
        end
        checks++;
        if ({out_result, out_rd, out_exec, out_we} !== 9'd0) begin
            failures++;
            $display("FAIL reset_outs got=%h exp=0", {out_result, out_rd, out_exec, out_we});
        end
        for (int a = 0; a < 4; a++) begin
            rd_addr = a[1:0]; #1;
            checks++;
            if (rd_data !== 5'd0) begin
                failures++;
                $display("FAIL reset_rd_data addr=%0d got=%h exp=00", a, rd_data);
            end
        end
`ifdef COND_STATS_EN
        checks++;
        if ({exec_count, skip_count} !== 16'd0) begin
            failures++;
            $display("FAIL reset_counters got=%h/%h exp=0/0", exec_count, skip_count);
        end
`endif
    endtask

    task automatic test_basic();
        drive(1, 5'h00, 4'b0100, 4'd14, 2'b11, 1, 2'd1, 1);
        tick();
        rd_addr = 2'd1; #1;
        checks++;
        if ({out_valid, out_exec, out_we, flags, rd_data} !== {1'b1, 1'b1, 1'b1, 4'b0100, 5'h00}) begin
            failures++;
            $display("FAIL basic_al got=%b_%b_%b_%b_%h exp=1_1_1_0100_00", out_valid, out_exec, out_we, flags, rd_data);
        end
        drive(1, 5'h1F, 4'b0000, 4'd0, 2'b00, 1, 2'd2, 1);
        rd_addr = 2'd2; #1;
        checks++;
        if (rd_data !== 5'h00) begin
            failures++;
            $display("FAIL basic_same_cycle_read got=%h exp=00", rd_data);
        end
        tick();
        checks++;
        if ({out_exec, out_we, out_result, out_rd, flags, rd_data} !== {1'b1, 1'b1, 5'h1F, 2'd2, 4'b0100, 5'h1F}) begin
            failures++;
            $display("FAIL basic_eq got=%b_%b_%h_%0d_%b_%h exp=1_1_1f_2_0100_1f",
                     out_exec, out_we, out_result, out_rd, flags, rd_data);
        end
    endtask

    task automatic test_skip();
        drive(1, 5'h00, 4'b0000, 4'd14, 2'b11, 0, 2'd0, 1);
        tick();
        drive(1, 5'h0A, 4'b1111, 4'd0, 2'b11, 1, 2'd3, 1);
        tick();
        rd_addr = 2'd3; #1;
        checks++;
        if ({out_valid, out_exec, out_we, out_result, flags, rd_data} !== {1'b1, 1'b0, 1'b0, 5'h0A, 4'b0000, 5'h00}) begin
            failures++;
            $display("FAIL skip_eq got=%b_%b_%b_%h_%b_%h exp=1_0_0_0a_0000_00",
                     out_valid, out_exec, out_we, out_result, flags, rd_data);
        end
`ifdef COND_STATS_EN
        checks++;
        if ({exec_count, skip_count} !== {8'd3, 8'd1}) begin
            failures++;
            $display("FAIL skip_counters got=%0d/%0d exp=3/1", exec_count, skip_count);
        end
`endif
    endtask

    task automatic test_signed();
        logic [3:0] fl [3];
        logic [3:0] cc [5];
        logic       ex [5];
        int         fi [5];
        fl[0] = 4'b1000; fl[1] = 4'b1001; fl[2] = 4'b0010;
        cc[0] = 4'd10; ex[0] = 0; fi[0] = 0;
        cc[1] = 4'd11; ex[1] = 1; fi[1] = 0;
        cc[2] = 4'd12; ex[2] = 1; fi[2] = 1;
        cc[3] = 4'd13; ex[3] = 0; fi[3] = 1;
        cc[4] = 4'd8;  ex[4] = 1; fi[4] = 2;
        for (int k = 0; k < 5; k++) begin
            if (k == 0 || fi[k] != fi[k-1]) begin
                drive(1, 5'h00, fl[fi[k]], 4'd14, 2'b11, 0, 2'd0, 1);
                tick();
            end
            drive(1, 5'h05, 4'b0000, cc[k], 2'b00, 0, 2'd0, 1);
            tick();
            checks++;
            if ({out_exec, flags} !== {ex[k], fl[fi[k]]}) begin
                failures++;
                $display("FAIL signed_cond cond=%0d got=%b_%b exp=%b_%b", cc[k], out_exec, flags, ex[k], fl[fi[k]]);
            end
        end
    endtask

    task automatic test_backpressure();
        drive(1, 5'h05, 4'b0000, 4'd14, 2'b00, 0, 2'd1, 1);
        tick();
        drive(1, 5'h1A, 4'b1111, 4'd14, 2'b11, 1, 2'd3, 0);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_in_ready got=%b exp=0", in_ready);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({out_valid, out_result, out_rd, in_ready} !== {1'b1, 5'h05, 2'd1, 1'b0}) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got=%b_%h_%0d_%b exp=1_05_1_0", k, out_valid, out_result, out_rd, in_ready);
            end
        end
        drive(1, 5'h0C, 4'b0000, 4'd14, 2'b00, 1, 2'd2, 1);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release_ready got=%b exp=1", in_ready);
        end
        tick();
        rd_addr = 2'd3; #1;
        checks++;
        if ({out_valid, out_result, out_rd, rd_data, flags} !== {1'b1, 5'h0C, 2'd2, 5'h00, m_flags}) begin
            failures++;
            $display("FAIL bp_drain_accept got=%b_%h_%0d_%h_%b exp=1_0c_2_00_%b",
                     out_valid, out_result, out_rd, rd_data, flags, m_flags);
        end
    endtask

    task automatic test_reset_inflight();
        drive(1, 5'h11, 4'b0000, 4'd14, 2'b00, 0, 2'd0, 0);
        tick();
        drive(1, 5'h1F, 4'b1111, 4'd14, 2'b11, 1, 2'd0, 0);
        reset = 1;
        tick();
        reset = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({out_valid, flags, in_ready, out_result} !== {1'b0, 4'b0000, 1'b1, 5'h00}) begin
            failures++;
            $display("FAIL rst_inflight got=%b_%b_%b_%h exp=0_0000_1_00", out_valid, flags, in_ready, out_result);
        end
        for (int a = 0; a < 4; a++) begin
            rd_addr = a[1:0]; #1;
            checks++;
            if (rd_data !== 5'd0) begin
                failures++;
                $display("FAIL rst_inflight_reg addr=%0d got=%h exp=00", a, rd_data);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            reset = (i == 500) ? 1'b1 : 1'b0;
            drive($urandom_range(0, 3) != 0, 5'($urandom), 4'($urandom), 4'($urandom),
                  2'($urandom), 1'($urandom), 2'($urandom), $urandom_range(0, 3) != 0);
            checks++;
            if (in_ready !== (!m_ov || out_ready)) begin
                failures++;
                $display("FAIL rand_in_ready i=%0d got=%b exp=%b", i, in_ready, !m_ov || out_ready);
            end
            tick();
            rd_addr = 2'($urandom); #1;
            checks++;
            if ({out_valid, out_result, out_rd, out_exec, out_we, flags, rd_data} !==
                {m_ov, m_res, m_rd, m_exec, m_we, m_flags, m_regs[rd_addr]}) begin
                failures++;
                $display("FAIL rand_state i=%0d got=%b_%h_%0d_%b_%b_%b_%h exp=%b_%h_%0d_%b_%b_%b_%h", i,
                         out_valid, out_result, out_rd, out_exec, out_we, flags, rd_data,
                         m_ov, m_res, m_rd, m_exec, m_we, m_flags, m_regs[rd_addr]);
            end
`ifdef COND_STATS_EN
            checks++;
            if ({exec_count, skip_count} !== {m_ec, m_sc}) begin
                failures++;
                $display("FAIL rand_counters i=%0d got=%0d/%0d exp=%0d/%0d", i, exec_count, skip_count, m_ec, m_sc);
            end
`endif
        end
    endtask

    initial begin
        reset = 1; rd_addr = 0;
        m_flags = 0; m_ov = 0; m_res = 0; m_rd = 0; m_exec = 0; m_we = 0; m_ec = 0; m_sc = 0;
        for (int i = 0; i < 4; i++) m_regs[i] = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        test_reset();
        test_basic();
        test_skip();
        test_signed();
        test_backpressure();
        test_reset_inflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
